// File: rtl/axi4l_wb_bridge.sv
// Pipelined Wishbone slave to AXI4-Lite master bridge with one outstanding
// transaction and an optional response timeout.
module axi4l_wb_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         wb_cyc_i,
    input  logic                                         wb_stb_i,
    input  logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0]                      wb_sel_i,
    input  logic                                         wb_we_i,
    input  logic [DATA_WIDTH-1:0]                        wb_dat_i,
    output logic                                         wb_ack_o,
    output logic                                         wb_err_o,
    output logic                                         wb_stall_o,
    output logic [DATA_WIDTH-1:0]                        wb_dat_o,
    output logic                                         blk_awvalid_o,
    input  logic                                         blk_awready_i,
    output logic [ADDR_WIDTH-1:0]                        blk_awaddr_o,
    output logic                                         blk_wvalid_o,
    input  logic                                         blk_wready_i,
    output logic [DATA_WIDTH-1:0]                        blk_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                      blk_wstrb_o,
    input  logic                                         blk_bvalid_i,
    output logic                                         blk_bready_o,
    input  logic [1:0]                                   blk_bresp_i,
    output logic                                         blk_arvalid_o,
    input  logic                                         blk_arready_i,
    output logic [ADDR_WIDTH-1:0]                        blk_araddr_o,
    input  logic                                         blk_rvalid_i,
    output logic                                         blk_rready_o,
    input  logic [DATA_WIDTH-1:0]                        blk_rdata_i,
    input  logic [1:0]                                   blk_rresp_i
);

    localparam int AL      = $clog2(DATA_WIDTH/8);
    localparam int SW      = DATA_WIDTH/8;
    localparam int WAW     = ADDR_WIDTH - AL;
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WAW-1:0]    adr_q, adr_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;
    logic              timeout_s;
    logic              unused_s;

    // Only resp[1] distinguishes success from failure; EXOKAY counts as OK.
    assign unused_s  = ^{blk_bresp_i[0], blk_rresp_i[0]};
    assign timeout_s = (TIMEOUT > 0) && (count_q == TO_LAST_C);

    // Next-state, handshake and response-pulse logic.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        if (state_q == S_IDLE) begin
            count_d = '0;
        end else if (count_q == TO_LAST_C) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d = wb_adr_i;
                    sel_d = wb_sel_i;
                    dat_d = wb_dat_i;
                    if (wb_we_i) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WADDR: begin
                if (timeout_s) begin
                    state_d   = S_IDLE;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    err_d     = wb_cyc_i;
                end else begin
                    // AW and W retire independently; move on once both are gone.
                    awvalid_d = awvalid_q & ~blk_awready_i;
                    wvalid_d  = wvalid_q & ~blk_wready_i;
                    if (!(awvalid_q & ~blk_awready_i) && !(wvalid_q & ~blk_wready_i)) begin
                        state_d  = S_WRESP;
                        bready_d = 1'b1;
                    end else begin
                        state_d  = S_WADDR;
                    end
                end
            end
            S_WRESP: begin
                if (blk_bvalid_i) begin
                    state_d = S_IDLE;
                    ack_d   = wb_cyc_i & ~blk_bresp_i[1];
                    err_d   = wb_cyc_i & blk_bresp_i[1];
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    err_d   = wb_cyc_i;
                end else begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_RADDR: begin
                if (timeout_s) begin
                    state_d   = S_IDLE;
                    arvalid_d = 1'b0;
                    err_d     = wb_cyc_i;
                end else if (blk_arready_i) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d   = S_RADDR;
                end
            end
            S_RDATA: begin
                if (blk_rvalid_i) begin
                    state_d = S_IDLE;
                    rdata_d = blk_rdata_i;
                    ack_d   = wb_cyc_i & ~blk_rresp_i[1];
                    err_d   = wb_cyc_i & blk_rresp_i[1];
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    err_d   = wb_cyc_i;
                end else begin
                    state_d  = S_RDATA;
                    rready_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        stall_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;
    assign wb_stall_o    = stall_q;
    assign wb_dat_o      = rdata_q;
    assign blk_awvalid_o = awvalid_q;
    assign blk_awaddr_o  = {adr_q, {AL{1'b0}}};
    assign blk_wvalid_o  = wvalid_q;
    assign blk_wdata_o   = dat_q;
    assign blk_wstrb_o   = sel_q;
    assign blk_bready_o  = bready_q;
    assign blk_arvalid_o = arvalid_q;
    assign blk_araddr_o  = {adr_q, {AL{1'b0}}};
    assign blk_rready_o  = rready_q;

endmodule

// File: tb/tb_axi4l_wb_bridge.sv
// Directed bench for axi4l_wb_bridge: scoreboard queues for the main instance,
// plus a TIMEOUT=8 instance and a 64-bit instance.
module tb_axi4l_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, we, stb_m, stb_t, stb_x;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic        m_ack, m_err, m_stall, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_dat, m_wdata;
    logic [11:0] m_awaddr, m_araddr;
    logic [3:0]  m_wstrb;

    logic        t_ack, t_err, t_stall, t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;
    logic [31:0] t_dat, t_wdata;
    logic [11:0] t_awaddr, t_araddr;
    logic [3:0]  t_wstrb;

    logic [8:0]  x_adr;
    logic [7:0]  x_sel;
    logic [63:0] x_datw, x_rdata;
    logic        x_awready, x_wready, x_bvalid, x_arready, x_rvalid;
    logic [1:0]  x_bresp, x_rresp;
    logic        x_ack, x_err, x_stall, x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready;
    logic [63:0] x_dat, x_wdata;
    logic [11:0] x_awaddr, x_araddr;
    logic [7:0]  x_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_aw[$];
    logic [11:0] exp_ar[$];
    logic [35:0] exp_w[$];
    logic [33:0] exp_resp[$];   // {is_err, check_data, data}

    always #5 clk = ~clk;

    axi4l_wb_bridge u_dut (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb_m), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(m_ack), .wb_err_o(m_err),
        .wb_stall_o(m_stall), .wb_dat_o(m_dat), .blk_awvalid_o(m_awvalid),
        .blk_awready_i(awready), .blk_awaddr_o(m_awaddr), .blk_wvalid_o(m_wvalid),
        .blk_wready_i(wready), .blk_wdata_o(m_wdata), .blk_wstrb_o(m_wstrb),
        .blk_bvalid_i(bvalid), .blk_bready_o(m_bready), .blk_bresp_i(bresp),
        .blk_arvalid_o(m_arvalid), .blk_arready_i(arready), .blk_araddr_o(m_araddr),
        .blk_rvalid_i(rvalid), .blk_rready_o(m_rready), .blk_rdata_i(rdata),
        .blk_rresp_i(rresp)
    );

    axi4l_wb_bridge #(.TIMEOUT(8)) u_to (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb_t), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(t_ack), .wb_err_o(t_err),
        .wb_stall_o(t_stall), .wb_dat_o(t_dat), .blk_awvalid_o(t_awvalid),
        .blk_awready_i(awready), .blk_awaddr_o(t_awaddr), .blk_wvalid_o(t_wvalid),
        .blk_wready_i(wready), .blk_wdata_o(t_wdata), .blk_wstrb_o(t_wstrb),
        .blk_bvalid_i(bvalid), .blk_bready_o(t_bready), .blk_bresp_i(bresp),
        .blk_arvalid_o(t_arvalid), .blk_arready_i(arready), .blk_araddr_o(t_araddr),
        .blk_rvalid_i(rvalid), .blk_rready_o(t_rready), .blk_rdata_i(rdata),
        .blk_rresp_i(rresp)
    );

    axi4l_wb_bridge #(.DATA_WIDTH(64)) u_w64 (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb_x), .wb_adr_i(x_adr),
        .wb_sel_i(x_sel), .wb_we_i(we), .wb_dat_i(x_datw), .wb_ack_o(x_ack), .wb_err_o(x_err),
        .wb_stall_o(x_stall), .wb_dat_o(x_dat), .blk_awvalid_o(x_awvalid),
        .blk_awready_i(x_awready), .blk_awaddr_o(x_awaddr), .blk_wvalid_o(x_wvalid),
        .blk_wready_i(x_wready), .blk_wdata_o(x_wdata), .blk_wstrb_o(x_wstrb),
        .blk_bvalid_i(x_bvalid), .blk_bready_o(x_bready), .blk_bresp_i(x_bresp),
        .blk_arvalid_o(x_arvalid), .blk_arready_i(x_arready), .blk_araddr_o(x_araddr),
        .blk_rvalid_i(x_rvalid), .blk_rready_o(x_rready), .blk_rdata_i(x_rdata),
        .blk_rresp_i(x_rresp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with no expectation queued", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [9:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; we = w; adr = a; sel = s; dat = d; stb_m = 1'b1;
        tick();
        stb_m = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the main instance shows a handshake or response.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst) begin
            if (m_awvalid && awready) begin
                if (exp_aw.size() == 0) unexpected("aw_hs");
                else check("awaddr", {52'h0, m_awaddr}, {52'h0, exp_aw.pop_front()});
            end
            if (m_wvalid && wready) begin
                if (exp_w.size() == 0) unexpected("w_hs");
                else check("wdata_wstrb", {28'h0, m_wdata, m_wstrb}, {28'h0, exp_w.pop_front()});
            end
            if (m_arvalid && arready) begin
                if (exp_ar.size() == 0) unexpected("ar_hs");
                else check("araddr", {52'h0, m_araddr}, {52'h0, exp_ar.pop_front()});
            end
            if (m_ack || m_err) begin
                check("ack_err_excl", {63'h0, m_ack & m_err}, 64'h0);
                if (exp_resp.size() == 0) unexpected("wb_resp");
                else begin
                    e = exp_resp.pop_front();
                    check("resp_is_err", {63'h0, m_err}, {63'h0, e[33]});
                    if (e[32]) check("resp_dat", {32'h0, m_dat}, {32'h0, e[31:0]});
                end
            end
        end
    end

    task automatic wr_m(input logic [9:0] a, input logic [3:0] s, input logic [31:0] d,
                        input int dly, input logic [1:0] br);
        exp_aw.push_back({a, 2'b00});
        exp_w.push_back({d, s});
        exp_resp.push_back({br[1], 1'b0, 32'h0});
        awready = 1'b1;
        wready  = (dly == 0);
        issue(1'b1, a, s, d);
        check("wr_stall", {63'h0, m_stall}, 64'h1);
        check("wr_awvalid", {63'h0, m_awvalid}, 64'h1);
        check("wr_wvalid", {63'h0, m_wvalid}, 64'h1);
        for (int k = 1; k <= dly; k++) begin
            tick();
            awready = 1'b0;
            check("wr_awvalid_dropped", {63'h0, m_awvalid}, 64'h0);
            check("wr_wvalid_held", {63'h0, m_wvalid}, 64'h1);
            check("wr_wdata_stable", {28'h0, m_wdata, m_wstrb}, {28'h0, d, s});
            if (k == dly) wready = 1'b1;
        end
        tick();
        awready = 1'b0; wready = 1'b0;
        check("wr_both_dropped", {62'h0, m_awvalid, m_wvalid}, 64'h0);
        check("wr_bready", {63'h0, m_bready}, 64'h1);
        bvalid = 1'b1; bresp = br;
        tick();
        bvalid = 1'b0;
        check("wr_ack", {63'h0, m_ack}, {63'h0, ~br[1]});
        check("wr_err", {63'h0, m_err}, {63'h0, br[1]});
        check("wr_stall_released", {62'h0, m_stall, m_bready}, 64'h0);
        tick();
        check("wr_pulse_end", {62'h0, m_ack, m_err}, 64'h0);
    endtask

    task automatic rd_m(input logic [9:0] a, input logic [31:0] rd, input logic [1:0] rr, input logic drop);
        exp_ar.push_back({a, 2'b00});
        if (!drop) exp_resp.push_back({rr[1], 1'b1, rd});
        arready = 1'b1;
        issue(1'b0, a, 4'h0, 32'h0);
        if (drop) cyc = 1'b0;
        check("rd_arvalid", {63'h0, m_arvalid}, 64'h1);
        tick();
        arready = 1'b0;
        check("rd_arvalid_dropped", {63'h0, m_arvalid}, 64'h0);
        check("rd_rready", {63'h0, m_rready}, 64'h1);
        rvalid = 1'b1; rdata = rd; rresp = rr;
        tick();
        rvalid = 1'b0;
        check("rd_ack", {63'h0, m_ack}, {63'h0, ~drop & ~rr[1]});
        check("rd_err", {63'h0, m_err}, {63'h0, ~drop & rr[1]});
        check("rd_dat", {32'h0, m_dat}, {32'h0, rd});
        check("rd_idle", {62'h0, m_stall, m_rready}, 64'h0);
        tick();
        check("rd_pulse_end", {62'h0, m_ack, m_err}, 64'h0);
        check("rd_dat_held", {32'h0, m_dat}, {32'h0, rd});
        cyc = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; we = 1'b0; stb_m = 1'b0; stb_t = 1'b0; stb_x = 1'b0;
        adr = 10'h0; sel = 4'h0; dat = 32'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        x_adr = 9'h0; x_sel = 8'h0; x_datw = 64'h0; x_awready = 1'b0; x_wready = 1'b0;
        x_bvalid = 1'b0; x_bresp = 2'b00; x_arready = 1'b0; x_rvalid = 1'b0;
        x_rdata = 64'h0; x_rresp = 2'b00;
        tick(); tick();

        check("rst_main_ctl", {56'h0, m_ack, m_err, m_stall, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'h0);
        check("rst_main_dat", {32'h0, m_dat}, 64'h0);
        check("rst_main_addr", {8'h0, m_awaddr, m_araddr, m_wdata}, 64'h0);
        check("rst_main_wstrb", {60'h0, m_wstrb}, 64'h0);
        check("rst_to_ctl", {56'h0, t_ack, t_err, t_stall, t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready}, 64'h0);
        check("rst_to_data", {t_dat, t_wdata}, 64'h0);
        check("rst_to_addr", {36'h0, t_awaddr, t_araddr, t_wstrb}, 64'h0);
        check("rst_x_ctl", {56'h0, x_ack, x_err, x_stall, x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready}, 64'h0);
        check("rst_x_dat", x_dat, 64'h0);
        check("rst_x_addr", {32'h0, x_awaddr, x_araddr, x_wstrb}, 64'h0);
        rst = 1'b0;
        tick();

        wr_m(10'h003, 4'hF, 32'hDEADBEEF, 0, 2'b00);
        wr_m(10'h010, 4'h3, 32'hCAFEF00D, 3, 2'b00);
        wr_m(10'h3FF, 4'h8, 32'h000000A5, 1, 2'b11);
        rd_m(10'h001, 32'h12345678, 2'b10, 1'b0);
        rd_m(10'h3FF, 32'hA5A50F0F, 2'b01, 1'b0);
        rd_m(10'h005, 32'h5555AAAA, 2'b00, 1'b1);

        // Reset while the bridge waits in WRESP.
        exp_aw.push_back(12'h080);
        exp_w.push_back({32'h11112222, 4'hF});
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 10'h020, 4'hF, 32'h11112222);
        tick();
        awready = 1'b0; wready = 1'b0;
        check("rstw_bready", {63'h0, m_bready}, 64'h1);
        bvalid = 1'b1; bresp = 2'b00;
        #2 rst = 1'b1;
        #1;
        check("rstw_ctl", {56'h0, m_ack, m_err, m_stall, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'h0);
        check("rstw_dat", {32'h0, m_dat}, 64'h0);
        tick();
        bvalid = 1'b0; rst = 1'b0;
        tick();
        check("rstw_no_resp", {61'h0, m_ack, m_err, m_stall}, 64'h0);
        rd_m(10'h002, 32'h0BADF00D, 2'b00, 1'b0);

        // Timeout instance: arready never comes.
        arready = 1'b0; cyc = 1'b1; we = 1'b0; adr = 10'h055; stb_t = 1'b1;
        tick();
        stb_t = 1'b0;
        check("to_araddr", {52'h0, t_araddr}, 64'h154);
        for (int k = 0; k < 8; k++) begin
            check("to_waiting", {61'h0, t_arvalid, t_err, t_stall}, 64'h5);
            tick();
        end
        check("to_fired", {61'h0, t_arvalid, t_err, t_stall}, 64'h2);
        rvalid = 1'b1; rdata = 32'hFFFF0000; rresp = 2'b00;
        check("to_late_rready", {63'h0, t_rready}, 64'h0);
        tick();
        rvalid = 1'b0;
        check("to_after", {60'h0, t_arvalid, t_err, t_ack, t_stall}, 64'h0);
        check("to_dat_untouched", {32'h0, t_dat}, 64'h0);

        // 64-bit instance: write then read at the top word.
        x_awready = 1'b1; x_wready = 1'b1; we = 1'b1; x_adr = 9'h002; x_sel = 8'h0F;
        x_datw = 64'h0123456789ABCDEF; stb_x = 1'b1;
        tick();
        stb_x = 1'b0;
        check("x_awaddr", {52'h0, x_awaddr}, 64'h010);
        check("x_wstrb", {56'h0, x_wstrb}, 64'h0F);
        check("x_wdata", x_wdata, 64'h0123456789ABCDEF);
        check("x_valids", {62'h0, x_awvalid, x_wvalid}, 64'h3);
        tick();
        x_awready = 1'b0; x_wready = 1'b0;
        check("x_bready", {61'h0, x_awvalid, x_wvalid, x_bready}, 64'h1);
        x_bvalid = 1'b1;
        tick();
        x_bvalid = 1'b0;
        check("x_wr_resp", {62'h0, x_ack, x_err}, 64'h2);
        x_arready = 1'b1; we = 1'b0; x_adr = 9'h1FF; stb_x = 1'b1;
        tick();
        stb_x = 1'b0;
        check("x_araddr", {52'h0, x_araddr}, 64'hFF8);
        check("x_arvalid", {63'h0, x_arvalid}, 64'h1);
        tick();
        x_arready = 1'b0;
        check("x_rready", {63'h0, x_rready}, 64'h1);
        x_rvalid = 1'b1; x_rdata = 64'hFEDCBA9876543210; x_rresp = 2'b01;
        tick();
        x_rvalid = 1'b0;
        check("x_rd_resp", {61'h0, x_ack, x_err, x_stall}, 64'h4);
        check("x_rd_dat", x_dat, 64'hFEDCBA9876543210);

        tick(); tick();
        check("q_aw_empty", 64'(exp_aw.size()), 64'h0);
        check("q_w_empty", 64'(exp_w.size()), 64'h0);
        check("q_ar_empty", 64'(exp_ar.size()), 64'h0);
        check("q_resp_empty", 64'(exp_resp.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4l_wb_bridge.md
AXI4L_WB_BRIDGE -- requirements
Module: axi4l_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, AXI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal 32 or 64; AL = log2(DATA_WIDTH/8).
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waiting for AXI; 0 disables the timeout.
REQ-004 SHALL have port clk_i  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wb_cyc_i  in  1  Wishbone cycle.
REQ-007 SHALL have port wb_stb_i  in  1  Wishbone strobe.
REQ-008 SHALL have port wb_adr_i  in  ADDR_WIDTH-AL  word address.
REQ-009 SHALL have port wb_sel_i  in  DATA_WIDTH/8  byte selects.
REQ-010 SHALL have port wb_we_i  in  1  write enable.
REQ-011 SHALL have port wb_dat_i  in  DATA_WIDTH  write data.
REQ-012 SHALL have port wb_ack_o  out  1  one-cycle success pulse.
REQ-013 SHALL have port wb_err_o  out  1  one-cycle error pulse.
REQ-014 SHALL have port wb_stall_o  out  1  pipelined stall.
REQ-015 SHALL have port wb_dat_o  out  DATA_WIDTH  read data.
REQ-016 SHALL have port blk_awvalid_o  out  1  write address valid.
REQ-017 SHALL have port blk_awready_i  in  1  write address ready.
REQ-018 SHALL have port blk_awaddr_o  out  ADDR_WIDTH  write byte address.
REQ-019 SHALL have port blk_wvalid_o  out  1  write data valid.
REQ-020 SHALL have port blk_wready_i  in  1  write data ready.
REQ-021 SHALL have port blk_wdata_o  out  DATA_WIDTH  write data.
REQ-022 SHALL have port blk_wstrb_o  out  DATA_WIDTH/8  write strobes.
REQ-023 SHALL have port blk_bvalid_i  in  1  write response valid.
REQ-024 SHALL have port blk_bready_o  out  1  write response ready.
REQ-025 SHALL have port blk_bresp_i  in  2  write response code.
REQ-026 SHALL have port blk_arvalid_o  out  1  read address valid.
REQ-027 SHALL have port blk_arready_i  in  1  read address ready.
REQ-028 SHALL have port blk_araddr_o  out  ADDR_WIDTH  read byte address.
REQ-029 SHALL have port blk_rvalid_i  in  1  read data valid.
REQ-030 SHALL have port blk_rready_o  out  1  read data ready.
REQ-031 SHALL have port blk_rdata_i  in  DATA_WIDTH  read data.
REQ-032 SHALL have port blk_rresp_i  in  2  read response code.

Function
REQ-033 SHALL implement FSM IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA; one outstanding transaction only.
REQ-034 SHALL accept a request in IDLE when wb_cyc_i&wb_stb_i, latch adr/sel/we/dat, go to WADDR (we=1) or RADDR (we=0); wb_stall_o = 0 in IDLE, 1 in all other states.
REQ-035 SHALL drive awvalid and wvalid high from the cycle after accept; each drops independently after its own ready handshake (same-cycle awready&wready legal); WADDR->WRESP when both done.
REQ-036 SHALL drive awaddr/araddr = {latched adr, AL zeros}, wdata = latched dat, wstrb = latched sel; all stable while the matching valid is high.
REQ-037 SHALL assert arvalid in RADDR until arready, then RDATA; bready=1 only in WRESP, rready=1 only in RDATA.
REQ-038 SHALL, on bvalid in WRESP or rvalid in RDATA, return to IDLE and pulse wb_ack_o the next cycle if resp[1]=0, else wb_err_o; never both; on rvalid capture rdata into wb_dat_o (held until the next read).
REQ-039 SHALL count cycles outside IDLE; when TIMEOUT>0 and count reaches TIMEOUT without response, drop all valids, pulse wb_err_o, return to IDLE; late responses not consumed.
REQ-040 SHALL complete an AXI transaction started even if wb_cyc_i drops, and suppress ack/err pulses when wb_cyc_i is low at response time.

Reset
REQ-041 SHALL on rst_i force immediately: state IDLE, counter 0, all valid/ready outputs 0, wb_ack_o/wb_err_o 0, wb_dat_o 0, wb_stall_o 0; reset mid-transaction abandons it without any ack/err.

Verification
REQ-042 SHALL cover write adr 0x3, sel 0xF, dat 0xDEADBEEF, awready/wready same cycle, bresp 00 -> awaddr 0x00C, wstrb 0xF, one wb_ack_o.
REQ-043 SHALL cover write with wready 3 cycles after awready -> awvalid drops first, wvalid held until wready, then single ack.
REQ-044 SHALL cover read adr 0x1, rdata 0x12345678, rresp 10 -> araddr 0x004, wb_err_o pulse, wb_dat_o 0x12345678, no ack.
REQ-045 SHALL cover TIMEOUT=8, arready never asserted -> arvalid low and wb_err_o pulse 8 cycles after accept, stall released.
REQ-046 SHALL cover rst_i asserted during WRESP -> all outputs to reset values same cycle, next request accepted normally.
REQ-047 SHALL cover DATA_WIDTH=64, write sel 0x0F adr 0x2 -> awaddr 0x010, wstrb 0x0F.
